// File: rtl/core_data_arbiter_if.sv
// core_data_arbiter_if: core-style data port (req/gnt/rvalid) bundle.
// master drives req/addr/we/be/wdata and receives gnt/rvalid/rdata;
// slave is the mirror image.
interface core_data_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  gnt;
    logic                  rvalid;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/core_data_arbiter.sv
// core_data_arbiter: round-robin share of one core data port between m0 (LSU) and m1 (debug/DMA).
// Ports: clk_i/rst_ni (async active-low reset); m0, m1 requester ports (slave);
// data downstream port (master) towards the AXI-lite bridge; err_o sticky spurious-response flag.
module core_data_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    core_data_arbiter_if.slave   m0,
    core_data_arbiter_if.slave   m1,
    core_data_arbiter_if.master  data,
    output logic                 err_o
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                     state_q, state_d;
    logic                       rr_ptr_q, lock_id_q;
    logic                       sel, sel_req, full, pop, hs, head, req;
    logic [ADDR_WIDTH-1:0]      sel_addr;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;

    // Selection is frozen while a request waits for grant; a full FIFO only
    // lets a request through when a response frees a slot in the same cycle.
    always_comb begin
        sel     = state_q == LOCKED ? lock_id_q : (m0.req & m1.req) ? rr_ptr_q : m1.req;
        sel_req = sel ? m1.req : m0.req;
        full    = count_q == CW'(MAX_OUTSTANDING);
        pop     = data.rvalid & (count_q != '0);
        req     = rst_ni & sel_req & (~full | pop);
        hs      = req & data.gnt;
        state_d = state_q == IDLE ? (req & ~data.gnt ? LOCKED : IDLE)
                                  : (data.gnt ? IDLE : LOCKED);
    end

    assign sel_addr    = sel ? m1.addr : m0.addr;
    assign head        = owner_q[rd_ptr_q];
    assign data.req    = req;
    assign data.addr   = sel_addr;
    assign data.we     = sel ? m1.we : m0.we;
    assign data.be     = sel ? m1.be : m0.be;
    assign data.wdata  = sel ? m1.wdata : m0.wdata;
    assign m0.gnt      = hs & ~sel;
    assign m1.gnt      = hs & sel;
    assign m0.rvalid   = pop & ~head;
    assign m1.rvalid   = pop & head;
    assign m0.rdata    = data.rdata;
    assign m1.rdata    = data.rdata;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            rr_ptr_q  <= 1'b0;
            lock_id_q <= 1'b0;
            owner_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_o     <= 1'b0;
        end else begin
            if (state_q == IDLE) lock_id_q <= sel;
            if (hs) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= wrap_inc(wr_ptr_q);
                rr_ptr_q          <= ~sel;
            end
            if (pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
            count_q <= count_q + CW'(hs) - CW'(pop);
            if (data.rvalid & ~pop) err_o <= 1'b1;
        end
endmodule

// File: tb/tb_core_data_arbiter.sv
// tb_core_data_arbiter: directed self-checking bench for core_data_arbiter.
module tb_core_data_arbiter;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic err_o;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_i = ~clk_i;

    core_data_arbiter_if #(.ADDR_WIDTH(32)) m0_if ();
    core_data_arbiter_if #(.ADDR_WIDTH(32)) m1_if ();
    core_data_arbiter_if #(.ADDR_WIDTH(32)) data_if ();

    core_data_arbiter #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .m0     (m0_if),
        .m1     (m1_if),
        .data   (data_if),
        .err_o  (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv_m0(input logic r, input logic [31:0] a);
        m0_if.req  = r;
        m0_if.addr = a;
    endtask

    task automatic drv_m1(input logic r, input logic [31:0] a);
        m1_if.req  = r;
        m1_if.addr = a;
    endtask

    task automatic drv_down(input logic g, input logic rv, input logic [31:0] rd);
        data_if.gnt    = g;
        data_if.rvalid = rv;
        data_if.rdata  = rd;
    endtask

    initial begin
        m0_if.we = 1'b0; m0_if.be = 4'hF; m0_if.wdata = 32'h0;
        m1_if.we = 1'b1; m1_if.be = 4'h3; m1_if.wdata = 32'hCAFE_F00D;
        drv_m0(1'b1, 32'h0);
        drv_m1(1'b1, 32'h0);
        drv_down(1'b1, 1'b0, 32'h0);
        #3;
        check("rst_data_req", data_if.req, 1'b0);
        check("rst_m0_gnt", m0_if.gnt, 1'b0);
        check("rst_m1_gnt", m1_if.gnt, 1'b0);
        check("rst_err", err_o, 1'b0);
        tick;
        tick;
        rst_ni = 1'b1;
        drv_m0(1'b0, 32'h0);
        drv_m1(1'b0, 32'h0);
        drv_down(1'b0, 1'b0, 32'h0);
        #1;
        check("idle_data_req", data_if.req, 1'b0);
        tick;

        // single m0 read
        drv_m0(1'b1, 32'h1000_0004);
        drv_down(1'b1, 1'b0, 32'h0);
        #1;
        check("rd_m0_gnt", m0_if.gnt, 1'b1);
        check("rd_m1_gnt", m1_if.gnt, 1'b0);
        check("rd_addr", data_if.addr, 32'h1000_0004);
        check("rd_we", data_if.we, 1'b0);
        tick;
        drv_m0(1'b0, 32'h0);
        drv_down(1'b0, 1'b0, 32'h0);
        #1;
        check("rd_wait_req", data_if.req, 1'b0);
        check("rd_wait_rv", m0_if.rvalid, 1'b0);
        tick;
        drv_down(1'b0, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("rd_m0_rvalid", m0_if.rvalid, 1'b1);
        check("rd_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
        check("rd_m1_rvalid", m1_if.rvalid, 1'b0);
        tick;
        drv_down(1'b0, 1'b0, 32'h0);
        #1;
        check("rd_err", err_o, 1'b0);

        // reset returns rr_ptr to m0 before the contention run
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        tick;

        // contention round-robin with responses one cycle after grant
        for (int c = 0; c < 5; c++) begin
            drv_m0(c < 4, 32'h100);
            drv_m1(c < 4, 32'h200);
            drv_down(1'b1, c >= 1, 32'hA000_0000 + c);
            #1;
            if (c < 4) begin
                check("rr_m0_gnt", m0_if.gnt, c % 2 == 0);
                check("rr_m1_gnt", m1_if.gnt, c % 2 == 1);
                check("rr_addr", data_if.addr, (c % 2 == 1) ? 32'h200 : 32'h100);
            end
            if (c == 1) begin
                check("rr_m1_we", data_if.we, 1'b1);
                check("rr_m1_be", data_if.be, 4'h3);
                check("rr_m1_wdata", data_if.wdata, 32'hCAFE_F00D);
            end
            if (c >= 1) begin
                check("rr_m0_rvalid", m0_if.rvalid, (c - 1) % 2 == 0);
                check("rr_m1_rvalid", m1_if.rvalid, (c - 1) % 2 == 1);
                check("rr_rdata", m1_if.rdata, 32'hA000_0000 + c);
            end
            tick;
        end
        drv_down(1'b0, 1'b0, 32'h0);

        // lock hold: m1 waits for grant, m0 joins, selection must not move
        for (int c = 0; c < 4; c++) begin
            drv_m1(1'b1, 32'h300);
            drv_m0(c >= 1, 32'h400);
            drv_down(c == 3, 1'b0, 32'h0);
            #1;
            check("lk_addr", data_if.addr, 32'h300);
            check("lk_req", data_if.req, 1'b1);
            check("lk_m1_gnt", m1_if.gnt, c == 3);
            check("lk_m0_gnt", m0_if.gnt, 1'b0);
            tick;
        end
        drv_m1(1'b0, 32'h0);
        drv_down(1'b1, 1'b0, 32'h0);
        #1;
        check("lk_next_m0_gnt", m0_if.gnt, 1'b1);
        check("lk_next_addr", data_if.addr, 32'h400);
        tick;
        drv_m0(1'b0, 32'h0);
        drv_down(1'b0, 1'b1, 32'h11);
        #1;
        check("lk_rv1_m1", m1_if.rvalid, 1'b1);
        check("lk_rv1_m0", m0_if.rvalid, 1'b0);
        tick;
        drv_down(1'b0, 1'b1, 32'h22);
        #1;
        check("lk_rv2_m0", m0_if.rvalid, 1'b1);
        check("lk_rv2_m1", m1_if.rvalid, 1'b0);
        tick;

        // outstanding limit of two
        drv_down(1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            drv_m0(1'b1, 32'h500 + 4 * (c > 2 ? 2 : c));
            #1;
            check("ol_req", data_if.req, c < 2);
            check("ol_m0_gnt", m0_if.gnt, c < 2);
            tick;
        end
        drv_down(1'b1, 1'b1, 32'h33);
        #1;
        check("ol_pop_gnt", m0_if.gnt, 1'b1);
        check("ol_pop_rvalid", m0_if.rvalid, 1'b1);
        check("ol_pop_addr", data_if.addr, 32'h508);
        tick;
        drv_m0(1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("ol_drain_rv", m0_if.rvalid, 1'b1);
            tick;
        end
        drv_down(1'b0, 1'b0, 32'h0);
        #1;
        check("ol_err", err_o, 1'b0);

        // in-order mixed responses: grants m0,m1,m0
        drv_m0(1'b1, 32'h600);
        drv_down(1'b1, 1'b0, 32'h0);
        #1;
        check("io_g0_m0", m0_if.gnt, 1'b1);
        tick;
        drv_m0(1'b0, 32'h0);
        drv_m1(1'b1, 32'h700);
        #1;
        check("io_g1_m1", m1_if.gnt, 1'b1);
        tick;
        drv_m1(1'b0, 32'h0);
        drv_m0(1'b1, 32'h604);
        #1;
        check("io_full_req", data_if.req, 1'b0);
        tick;
        drv_down(1'b1, 1'b1, 32'h44);
        #1;
        check("io_rv0_m0", m0_if.rvalid, 1'b1);
        check("io_rv0_m1", m1_if.rvalid, 1'b0);
        check("io_g2_m0", m0_if.gnt, 1'b1);
        tick;
        drv_m0(1'b0, 32'h0);
        drv_down(1'b0, 1'b1, 32'h55);
        #1;
        check("io_rv1_m1", m1_if.rvalid, 1'b1);
        check("io_rv1_m0", m0_if.rvalid, 1'b0);
        tick;
        drv_down(1'b0, 1'b0, 32'h0);
        #1;
        check("io_gap_m0", m0_if.rvalid, 1'b0);
        check("io_gap_m1", m1_if.rvalid, 1'b0);
        tick;
        drv_down(1'b0, 1'b1, 32'h66);
        #1;
        check("io_rv2_m0", m0_if.rvalid, 1'b1);
        check("io_rv2_m1", m1_if.rvalid, 1'b0);
        tick;
        // an empty FIFO accepts two grants back to back
        drv_m0(1'b1, 32'h800);
        drv_down(1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("io_empty_gnt", m0_if.gnt, 1'b1);
            tick;
        end
        drv_m0(1'b0, 32'h0);
        drv_down(1'b0, 1'b1, 32'h77);
        tick;
        tick;
        drv_down(1'b0, 1'b0, 32'h0);
        #1;
        check("io_err", err_o, 1'b0);

        // spurious response
        drv_down(1'b0, 1'b1, 32'h99);
        #1;
        check("sp_m0_rvalid", m0_if.rvalid, 1'b0);
        check("sp_m1_rvalid", m1_if.rvalid, 1'b0);
        tick;
        drv_down(1'b0, 1'b0, 32'h0);
        #1;
        check("sp_err_set", err_o, 1'b1);
        tick;
        tick;
        check("sp_err_sticky", err_o, 1'b1);
        drv_m0(1'b1, 32'h900);
        drv_down(1'b1, 1'b0, 32'h0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("sp_err_async_clr", err_o, 1'b0);
        check("sp_rst_req", data_if.req, 1'b0);
        check("sp_rst_gnt", m0_if.gnt, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
